// File: rtl/pc_update_seq.sv
// pc_update_seq: steps the multicycle datapath through one PC update per
// request (sequential, branch, jump, register jump, exception entry with a
// vector fetch from memory, exception return) and drives the next-PC select
// and the PC/EPC load strobes.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | ready for a request, all strobes low
// SEQ_WR   | PC <= ALU result (PC+4)
// BR_EVAL  | PC <= ALUOut when the latched condition holds on the flags
// JMP_WR   | PC <= shifted jump target
// JR_WR    | PC <= ALU result (register value)
// RTE_WR   | PC <= EPC
// EXC_SAVE | EPC <= PC, vector byte read issued
// EXC_WAIT | memory latency, vector address held
// EXC_LOAD | PC <= sign-extended vector byte
module pc_update_seq #(
  parameter logic [7:0] EXC_BASE = 8'd253,
  parameter int         MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_type,
  input  logic [1:0] br_cond,
  input  logic       alu_zero,
  input  logic       alu_gt,
  input  logic [1:0] exc_code,
  output logic [3:0] PCSource,
  output logic       PCWrite,
  output logic       EPCWrite,
  output logic       vec_rd,
  output logic [7:0] vec_addr,
  output logic       done,
  output logic [7:0] exc_count
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_SEQ_WR   = 4'd1,
    S_BR_EVAL  = 4'd2,
    S_JMP_WR   = 4'd3,
    S_JR_WR    = 4'd4,
    S_RTE_WR   = 4'd5,
    S_EXC_SAVE = 4'd6,
    S_EXC_WAIT = 4'd7,
    S_EXC_LOAD = 4'd8
  } state_t;

  localparam logic [1:0] WAIT_INIT = 2'(MEM_WAIT);

  localparam logic [2:0] T_SEQ    = 3'd0;
  localparam logic [2:0] T_BRANCH = 3'd1;
  localparam logic [2:0] T_JUMP   = 3'd2;
  localparam logic [2:0] T_JR     = 3'd3;
  localparam logic [2:0] T_EXC    = 3'd4;
  localparam logic [2:0] T_RTE    = 3'd5;

  state_t     state_q, state_d;
  logic [1:0] br_cond_q, br_cond_d;
  logic [1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] vec_addr_q, vec_addr_d;
  logic [7:0] exc_count_q, exc_count_d;
  logic [3:0] pc_source_q, pc_source_d;
  logic       pc_write_q, pc_write_d;
  logic       epc_write_q, epc_write_d;
  logic       vec_rd_q, vec_rd_d;
  logic       done_q, done_d;
  logic       req_ready_q, req_ready_d;
  logic [1:0] eff_code;
  logic       br_taken;

  // Next-state, request latching, wait counter and exception counter.
  always_comb begin
    state_d     = state_q;
    br_cond_d   = br_cond_q;
    wait_cnt_d  = wait_cnt_q;
    vec_addr_d  = vec_addr_q;
    exc_count_d = exc_count_q;
    eff_code    = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          br_cond_d = br_cond;
          case (req_type)
            T_SEQ:    state_d = S_SEQ_WR;
            T_BRANCH: state_d = S_BR_EVAL;
            T_JUMP:   state_d = S_JMP_WR;
            T_JR:     state_d = S_JR_WR;
            T_RTE:    state_d = S_RTE_WR;
            default: begin
              // EXC proper, or an illegal code taken as an opcode exception
              eff_code   = (req_type == T_EXC) ? exc_code : 2'd0;
              vec_addr_d = EXC_BASE + {6'd0, eff_code};
              state_d    = S_EXC_SAVE;
            end
          endcase
        end
      end
      S_EXC_SAVE: begin
        if (exc_count_q != 8'hFF) exc_count_d = exc_count_q + 8'd1;
        wait_cnt_d = WAIT_INIT;
        state_d    = S_EXC_WAIT;
      end
      S_EXC_WAIT: begin
        if (wait_cnt_q <= 2'd1) begin
          wait_cnt_d = 2'd0;
          state_d    = S_EXC_LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode of the upcoming state so the outputs come from flops.
  always_comb begin
    pc_source_d = 4'd0;
    pc_write_d  = 1'b0;
    epc_write_d = 1'b0;
    vec_rd_d    = 1'b0;
    done_d      = 1'b0;
    req_ready_d = 1'b0;
    case (state_d)
      S_IDLE:     req_ready_d = 1'b1;
      S_SEQ_WR:   begin pc_source_d = 4'd0; pc_write_d = 1'b1; done_d = 1'b1; end
      S_BR_EVAL:  begin pc_source_d = 4'd1; done_d = 1'b1; end
      S_JMP_WR:   begin pc_source_d = 4'd2; pc_write_d = 1'b1; done_d = 1'b1; end
      S_JR_WR:    begin pc_source_d = 4'd0; pc_write_d = 1'b1; done_d = 1'b1; end
      S_RTE_WR:   begin pc_source_d = 4'd3; pc_write_d = 1'b1; done_d = 1'b1; end
      S_EXC_SAVE: begin epc_write_d = 1'b1; vec_rd_d = 1'b1; end
      S_EXC_LOAD: begin pc_source_d = 4'd4; pc_write_d = 1'b1; done_d = 1'b1; end
      default:    pc_source_d = 4'd0;
    endcase
  end

  // Branch condition against the live ALU flags; only used in BR_EVAL.
  always_comb begin
    case (br_cond_q)
      2'd0:    br_taken = alu_zero;
      2'd1:    br_taken = ~alu_zero;
      2'd2:    br_taken = alu_gt;
      default: br_taken = ~alu_gt;
    endcase
  end

  // State and registered outputs; reset drops everything back to IDLE at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      br_cond_q   <= 2'd0;
      wait_cnt_q  <= 2'd0;
      vec_addr_q  <= 8'd0;
      exc_count_q <= 8'd0;
      pc_source_q <= 4'd0;
      pc_write_q  <= 1'b0;
      epc_write_q <= 1'b0;
      vec_rd_q    <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      br_cond_q   <= br_cond_d;
      wait_cnt_q  <= wait_cnt_d;
      vec_addr_q  <= vec_addr_d;
      exc_count_q <= exc_count_d;
      pc_source_q <= pc_source_d;
      pc_write_q  <= pc_write_d;
      epc_write_q <= epc_write_d;
      vec_rd_q    <= vec_rd_d;
      done_q      <= done_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign PCSource  = pc_source_q;
  assign PCWrite   = pc_write_q | ((state_q == S_BR_EVAL) & br_taken);
  assign EPCWrite  = epc_write_q;
  assign vec_rd    = vec_rd_q;
  assign vec_addr  = vec_addr_q;
  assign done      = done_q;
  assign req_ready = req_ready_q;
  assign exc_count = exc_count_q;

endmodule

// File: tb/tb_pc_update_seq.sv
// Bench for pc_update_seq: random and directed requests checked cycle by
// cycle against a timeline model built from the request rules.
module tb_pc_update_seq;

  localparam logic [7:0] BASE = 8'd253;
  localparam int         MW   = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_type;
  logic [1:0] br_cond;
  logic       alu_zero;
  logic       alu_gt;
  logic [1:0] exc_code;
  logic [3:0] PCSource;
  logic       PCWrite;
  logic       EPCWrite;
  logic       vec_rd;
  logic [7:0] vec_addr;
  logic       done;
  logic [7:0] exc_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_vec;
  int         exp_count;

  pc_update_seq #(.EXC_BASE(BASE), .MEM_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .br_cond(br_cond), .alu_zero(alu_zero), .alu_gt(alu_gt),
    .exc_code(exc_code), .PCSource(PCSource), .PCWrite(PCWrite), .EPCWrite(EPCWrite),
    .vec_rd(vec_rd), .vec_addr(vec_addr), .done(done), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  // Observed bundle: {PCSource, PCWrite, EPCWrite, vec_rd, done, req_ready, vec_addr}
  function automatic logic [16:0] pack(input logic [3:0] s, input logic pw, input logic ew,
                                       input logic vr, input logic d, input logic rdy,
                                       input logic [7:0] va);
    return {s, pw, ew, vr, d, rdy, va};
  endfunction

  // One request from an idle sequencer through to the cycle after done.
  task automatic run_req(input logic [2:0] t, input logic [1:0] c, input logic [1:0] e,
                         input bit rnd, input logic z, input logic g);
    logic [2:0]  et;
    logic [1:0]  ec;
    int          len;
    logic [16:0] exp_v;
    logic [3:0]  s;
    logic        pw, ew, vr, d, tk;
    et  = (t > 3'd5) ? 3'd4 : t;
    ec  = (t == 3'd4) ? e : 2'd0;
    len = (et == 3'd4) ? 2 + MW : 1;
    checks++;
    if (req_ready !== 1'b1 || PCWrite !== 1'b0 || EPCWrite !== 1'b0) begin
      errors++;
      $display("FAIL idle_before t=%0d: ready=%b pcw=%b epcw=%b required ready=1 pcw=0 epcw=0",
               t, req_ready, PCWrite, EPCWrite);
    end
    req_valid = 1'b1; req_type = t; br_cond = c; exc_code = e;
    if (et == 3'd4) exp_vec = BASE + {6'd0, ec};
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_type  = 3'($urandom_range(0, 7));
    br_cond   = 2'($urandom_range(0, 3));
    exc_code  = 2'($urandom_range(0, 3));
    for (int k = 1; k <= len; k++) begin
      if (rnd) begin alu_zero = 1'($urandom_range(0, 1)); alu_gt = 1'($urandom_range(0, 1)); end
      else begin alu_zero = z; alu_gt = g; end
      #1;
      s = 4'd0; pw = 1'b0; ew = 1'b0; vr = 1'b0; d = 1'b0;
      case (c)
        2'd0: tk = alu_zero;
        2'd1: tk = !alu_zero;
        2'd2: tk = alu_gt;
        default: tk = !alu_gt;
      endcase
      if (et == 3'd4) begin
        if (k == 1) begin ew = 1'b1; vr = 1'b1; end
        else if (k == len) begin s = 4'd4; pw = 1'b1; d = 1'b1; end
      end else begin
        d  = 1'b1;
        pw = (et == 3'd1) ? tk : 1'b1;
        s  = (et == 3'd1) ? 4'd1 : (et == 3'd2) ? 4'd2 : (et == 3'd5) ? 4'd3 : 4'd0;
      end
      exp_v = pack(s, pw, ew, vr, d, 1'b0, exp_vec);
      checks++;
      if (pack(PCSource, PCWrite, EPCWrite, vec_rd, done, req_ready, vec_addr) !== exp_v) begin
        errors++;
        $display("FAIL seq t=%0d c=%0d e=%0d cyc=%0d: got src=%0d pcw=%b epcw=%b vrd=%b done=%b rdy=%b va=%0d required src=%0d pcw=%b epcw=%b vrd=%b done=%b rdy=0 va=%0d",
                 t, c, e, k, PCSource, PCWrite, EPCWrite, vec_rd, done, req_ready, vec_addr,
                 s, pw, ew, vr, d, exp_vec);
      end
      if (k < len) begin @(posedge clk); #1; end
    end
    if (et == 3'd4 && exp_count < 255) exp_count++;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0 || PCWrite !== 1'b0 || vec_addr !== exp_vec ||
        exc_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL after_done t=%0d: rdy=%b done=%b pcw=%b va=%0d cnt=%0d required rdy=1 done=0 pcw=0 va=%0d cnt=%0d",
               t, req_ready, done, PCWrite, vec_addr, exc_count, exp_vec, exp_count);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_type = 3'd0; br_cond = 2'd0;
    alu_zero = 1'b0; alu_gt = 1'b0; exc_code = 2'd0;
    exp_vec = 8'd0; exp_count = 0;
    #12;
    checks++;
    if (pack(PCSource, PCWrite, EPCWrite, vec_rd, done, req_ready, vec_addr) !==
        pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0) || exc_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: src=%0d pcw=%b epcw=%b vrd=%b done=%b rdy=%b va=%0d cnt=%0d required 0 0 0 0 0 1 0 0",
               PCSource, PCWrite, EPCWrite, vec_rd, done, req_ready, vec_addr, exc_count);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_seq();
    run_req(3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    run_req(3'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);  // EQ, zero -> taken
    run_req(3'd1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1);  // LE, gt -> not taken
    run_req(3'd1, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0);  // NE, zero -> not taken
    run_req(3'd1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1);  // GT, gt -> taken
  endtask

  task automatic test_exc();
    checks++;
    if (exc_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL exc_count_before: got %0d required %0d", exc_count, exp_count);
    end
    run_req(3'd4, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);  // vec_addr 255, count 0 -> 1
    checks++;
    if (exc_count !== 8'd1 || vec_addr !== 8'd255) begin
      errors++;
      $display("FAIL exc_first: cnt=%0d va=%0d required cnt=1 va=255", exc_count, vec_addr);
    end
    run_req(3'd7, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0);  // illegal -> cause 0
    checks++;
    if (vec_addr !== 8'd253) begin
      errors++;
      $display("FAIL illegal_vec: va=%0d required 253", vec_addr);
    end
    run_req(3'd4, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0);  // 253+3 wraps to 0
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_type = 3'd2; br_cond = 2'd0; exc_code = 2'd0;
    @(posedge clk); #1;
    checks++;
    if (PCSource !== 4'd2 || PCWrite !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cyc1: src=%0d pcw=%b rdy=%b required src=2 pcw=1 rdy=0", PCSource, PCWrite, req_ready);
    end
    req_type = 3'd5;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || PCWrite !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cyc2: rdy=%b pcw=%b done=%b required rdy=1 pcw=0 done=0", req_ready, PCWrite, done);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (PCSource !== 4'd3 || PCWrite !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_cyc3: src=%0d pcw=%b done=%b required src=3 pcw=1 done=1", PCSource, PCWrite, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_type = 3'd4; exc_code = 2'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;              // EXC_WAIT
    reset_n = 1'b0;
    exp_vec = 8'd0; exp_count = 0;
    #1;
    checks++;
    if (pack(PCSource, PCWrite, EPCWrite, vec_rd, done, req_ready, vec_addr) !==
        pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0) || exc_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: src=%0d pcw=%b epcw=%b vrd=%b done=%b rdy=%b va=%0d cnt=%0d required 0 0 0 0 0 1 0 0",
               PCSource, PCWrite, EPCWrite, vec_rd, done, req_ready, vec_addr, exc_count);
    end
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (PCWrite !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_no_strobe cyc=%0d: pcw=%b done=%b rdy=%b required 0 0 1", i, PCWrite, done, req_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_req(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 256; i++)
      run_req(3'd4, 2'd0, 2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0);
    checks++;
    if (exc_count !== 8'd255) begin
      errors++;
      $display("FAIL exc_saturate: got %0d required 255", exc_count);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_exc();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_update_seq.md
# pc_update_seq

Sequencer that drives the next-PC source select and the PC/EPC write strobes of the multicycle datapath. It accepts one PC-update request per instruction from the main control unit and steps through the cycles needed to commit the new PC: sequential, branch, jump, register jump, exception entry with vector fetch from memory, and exception return. Its `PCSource` output feeds the next-PC multiplexer, and its strobes feed the PC and EPC registers.

## Interface
Parameters:
- `EXC_BASE`, default 8'd253: byte address of the first exception vector. Vector address is `EXC_BASE + exc_code`.
- `MEM_WAIT`, default 1: number of idle cycles between issuing the vector read and loading the PC (1..3).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  reset. Asynchronous, active-low.
- `req_valid`  in  1  a PC-update request is present.
- `req_ready`  out  1  the sequencer can accept a request. High only in IDLE.
- `req_type`  in  3  0=SEQ, 1=BRANCH, 2=JUMP, 3=JR, 4=EXC, 5=RTE. Codes 6 and 7 are illegal.
- `br_cond`  in  2  0=EQ, 1=NE, 2=GT, 3=LE. Sampled on acceptance.
- `alu_zero`  in  1  ALU zero flag, sampled in the BR_EVAL cycle.
- `alu_gt`  in  1  ALU greater-than flag, sampled in the BR_EVAL cycle.
- `exc_code`  in  2  exception cause: 0=opcode, 1=overflow, 2=div0. Sampled on acceptance.
- `PCSource`  out  4  next-PC select: 0=ALU result, 1=ALUOut, 2=shifted jump target, 3=EPC, 4=sign-extended vector byte.
- `PCWrite`  out  1  PC register load strobe.
- `EPCWrite`  out  1  EPC register load strobe.
- `vec_rd`  out  1  memory read strobe for the vector byte.
- `vec_addr`  out  8  address of the vector byte.
- `done`  out  1  one-cycle pulse when the request has completed.
- `exc_count`  out  8  number of exceptions taken. Saturates at 255.

## Operation
- States: IDLE, SEQ_WR, BR_EVAL, JMP_WR, JR_WR, RTE_WR, EXC_SAVE, EXC_WAIT, EXC_LOAD. Outputs are a Moore decode of the state, except the branch `PCWrite`.
- IDLE:
  - `req_ready`=1 and all strobes are 0.
  - When `req_valid`=1, the request is accepted. `req_type`, `br_cond` and `exc_code` are latched, and the FSM moves to the state for that type on the next edge.
  - An illegal `req_type` is treated as EXC with cause 0 (opcode).
- SEQ_WR: `PCSource`=0, `PCWrite`=1, `done`=1. Next state IDLE.
- BR_EVAL: `PCSource`=1 and `done`=1. Next state IDLE.
  - The branch is taken when: EQ and `alu_zero`; NE and not `alu_zero`; GT and `alu_gt`; LE and not `alu_gt`.
  - `PCWrite` equals the taken result, combinationally from the flags in this cycle.
- JMP_WR: `PCSource`=2, `PCWrite`=1, `done`=1. Next state IDLE.
- JR_WR: `PCSource`=0, `PCWrite`=1, `done`=1. Next state IDLE.
- RTE_WR: `PCSource`=3, `PCWrite`=1, `done`=1. Next state IDLE.
- EXC_SAVE:
  - `EPCWrite`=1 and `vec_rd`=1.
  - `vec_addr` = `EXC_BASE + exc_code`, 8-bit wrap-around.
  - `exc_count` increments unless it is already 255.
  - Next state EXC_WAIT.
- EXC_WAIT: `vec_addr` is held and the wait counter counts `MEM_WAIT` cycles. Then the FSM moves to EXC_LOAD.
- EXC_LOAD: `PCSource`=4, `PCWrite`=1, `done`=1. Next state IDLE.
- Outside IDLE, `req_valid` is ignored. A request held high is accepted only on return to IDLE.
- `PCWrite` and `EPCWrite` are never both 1 in the same cycle.
- In every state other than those listed above, `PCSource` defaults to 0.

## Timing
- Reset: asserting `reset_n` low immediately forces IDLE, including mid-sequence.
  - Reset values: `PCSource`=0, `PCWrite`=0, `EPCWrite`=0, `vec_rd`=0, `vec_addr`=0, `done`=0, `req_ready`=1, `exc_count`=0, wait counter 0.
  - A sequence interrupted by reset produces no further strobes.
- Acceptance is in cycle 0. SEQ, BRANCH, JUMP, JR and RTE write the PC in cycle 1, so their throughput is one request per 2 cycles.
- EXC timing: EPC write and vector read in cycle 1, wait cycles 2..1+`MEM_WAIT`, PC load in cycle 2+`MEM_WAIT`. With the default this is cycle 3.
- `done` coincides with the final write cycle. `req_ready` returns high on the following cycle.
- `vec_addr` is registered on acceptance and stays stable until the next EXC.

## Test plan
- Reset, then SEQ request: `req_ready`=1 at cycle 0; cycle 1 has `PCSource`=0, `PCWrite`=1, `done`=1; `req_ready`=1 at cycle 2.
- BRANCH EQ with `alu_zero`=1 gives `PCWrite`=1, `PCSource`=1. BRANCH LE with `alu_gt`=1 gives `PCWrite`=0, `done`=1.
- EXC with `exc_code`=2 and `MEM_WAIT`=1:
  - Cycle 1: `EPCWrite`=1, `vec_rd`=1, `vec_addr`=255.
  - Cycle 3: `PCSource`=4, `PCWrite`=1.
  - `exc_count` goes 0→1.
- JUMP, then RTE, back-to-back with `req_valid` held high: `PCSource` is 2 at cycle 1 and 3 at cycle 3. No request is accepted in cycle 1.
- Pull `reset_n` low in EXC_WAIT: outputs return to reset values immediately, and no `PCWrite` follows. Illegal `req_type`=7 runs the EXC sequence with `vec_addr`=253.
- 256 EXC requests: `exc_count` saturates at 255.
